// File: rtl/phase_generator_if.sv
// Tuning-word handshake between a frequency source and the phase generator.
interface phase_generator_if #(
    parameter int ACC_WIDTH = 24
);
    logic [ACC_WIDTH-1:0] freq_word;
    logic                 freq_valid;
    logic                 freq_ready;

    modport master (
        output freq_word,
        output freq_valid,
        input  freq_ready
    );

    modport slave (
        input  freq_word,
        input  freq_valid,
        output freq_ready
    );
endinterface

// File: rtl/phase_generator.sv
// DDS-style phase source for the CORDIC core.
// The accumulator advances by the active tuning word on every enabled cycle.
// The accumulator plus a phase offset is folded into a first-quadrant angle
// (0..PHASE_90) and a 2-bit quadrant code, which are driven from registers.
module phase_generator #(
    parameter int PHASE_WIDTH = 13,
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_90    = 3216,
    parameter int UPDATE_MODE = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   sync_clear,
    input  logic [ACC_WIDTH-1:0]   phase_offset,
    phase_generator_if.slave       freq_if,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic [1:0]             quadrant,
    output logic                   out_valid,
    output logic                   wrap
);

    localparam int F  = ACC_WIDTH - 2;            // fraction bits inside one quadrant
    localparam int PW = F + 1 + PHASE_WIDTH;      // full product width of m*PHASE_90

    // Maps an accumulator angle onto 0..PHASE_90. Quadrants II and IV run
    // backwards, so that the output is a triangle folded about pi/2.
    function automatic logic [PHASE_WIDTH-1:0] fold_phase(input logic [ACC_WIDTH-1:0] eff);
        logic [F:0]    m;
        logic [PW-1:0] prod;
        if (eff[F]) begin
            m = {1'b1, {F{1'b0}}} - {1'b0, eff[F-1:0]};
        end else begin
            m = {1'b0, eff[F-1:0]};
        end
        prod = PW'(m) * PW'(PHASE_90);
        return PHASE_WIDTH'(prod >> F);
    endfunction

    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   freq_active_q, freq_active_d;
    logic [ACC_WIDTH-1:0]   pend_q, pend_d;
    logic                   ready_q, ready_d;       // 1 = pending slot empty
    logic                   wrap_s1_q, wrap_s1_d;
    logic                   valid_s1_q, valid_s1_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [1:0]             quad_q, quad_d;
    logic                   out_valid_q, out_valid_d;
    logic                   wrap_q, wrap_d;

    logic [ACC_WIDTH:0]     sum_s;
    logic                   carry_s;
    logic                   accept_s;
    logic [ACC_WIDTH-1:0]   eff_s;

    assign sum_s    = {1'b0, acc_q} + {1'b0, freq_active_q};
    assign carry_s  = enable & ~sync_clear & sum_s[ACC_WIDTH];
    assign accept_s = freq_if.freq_valid & ready_q;
    assign eff_s    = acc_q + phase_offset;

    // Stage 1: accumulator advance with clear priority and carry detection.
    always_comb begin
        acc_d      = acc_q;
        wrap_s1_d  = 1'b0;
        valid_s1_d = enable;
        if (sync_clear) begin
            acc_d = {ACC_WIDTH{1'b0}};
        end else if (enable) begin
            acc_d     = sum_s[ACC_WIDTH-1:0];
            wrap_s1_d = sum_s[ACC_WIDTH];
        end else begin
            acc_d = acc_q;
        end
    end

    // Tuning-word update: immediate, or held until the next wrap / clear.
    always_comb begin
        freq_active_d = freq_active_q;
        pend_d        = pend_q;
        ready_d       = ready_q;
        if (UPDATE_MODE == 0) begin
            ready_d = 1'b1;
            if (accept_s) begin
                freq_active_d = freq_if.freq_word;
            end else begin
                freq_active_d = freq_active_q;
            end
        end else begin
            if (!ready_q) begin
                if (sync_clear || carry_s) begin
                    freq_active_d = pend_q;
                    ready_d       = 1'b1;
                end else begin
                    ready_d = 1'b0;
                end
            end else if (accept_s) begin
                pend_d  = freq_if.freq_word;
                ready_d = 1'b0;
            end else begin
                ready_d = 1'b1;
            end
        end
    end

    // Stage 2: fold the offset angle and align valid/wrap with it.
    always_comb begin
        phase_d     = fold_phase(eff_s);
        quad_d      = eff_s[ACC_WIDTH-1:ACC_WIDTH-2];
        out_valid_d = valid_s1_q;
        wrap_d      = wrap_s1_q;
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q         <= {ACC_WIDTH{1'b0}};
            freq_active_q <= {ACC_WIDTH{1'b0}};
            pend_q        <= {ACC_WIDTH{1'b0}};
            ready_q       <= 1'b1;
            wrap_s1_q     <= 1'b0;
            valid_s1_q    <= 1'b0;
            phase_q       <= {PHASE_WIDTH{1'b0}};
            quad_q        <= 2'b00;
            out_valid_q   <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            freq_active_q <= freq_active_d;
            pend_q        <= pend_d;
            ready_q       <= ready_d;
            wrap_s1_q     <= wrap_s1_d;
            valid_s1_q    <= valid_s1_d;
            phase_q       <= phase_d;
            quad_q        <= quad_d;
            out_valid_q   <= out_valid_d;
            wrap_q        <= wrap_d;
        end
    end

    assign freq_if.freq_ready = ready_q;
    assign phase              = phase_q;
    assign quadrant           = quad_q;
    assign out_valid          = out_valid_q;
    assign wrap               = wrap_q;

endmodule
